// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline: reset/NOP defaults, fetch FSM states
// and word-alignment helpers.
package pipeline_pkg;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit, with load, hold
// and flush (flush inserts a NOP bubble and beats both load and hold).
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] instr_next,
    input  logic [31:0] npc_next,
    output logic [31:0] instruction,
    output logic [31:0] npc,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instruction <= NOP_WORD;
            npc         <= '0;
            valid       <= 1'b0;
        end else if (load && !hold) begin
            instruction <= instr_next;
            npc         <= npc_next;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/i_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection and the imem
// req/ready handshake FSM feeding the IF/ID register.
module i_fetch
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        jump_in,
    input  logic [31:0] jump_target_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] instruction_out,
    output logic [31:0] npc_out,
    output logic        valid_out
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  pend_pc, pend_n;
    logic [31:0]  buf_instr, buf_instr_n;
    logic [31:0]  buf_npc, buf_npc_n;
    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_seq;
    logic         ifid_load;
    logic         ifid_flush;
    logic [31:0]  ifid_instr;
    logic [31:0]  ifid_npc;

    assign redirect      = jump_in | branch_taken_in;
    assign target        = word_align(jump_in ? jump_target_in : branch_target_in);
    assign pc_seq        = pc + 32'd4;
    assign imem_addr_out = word_align(pc);
    assign imem_req_out  = (state != HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= REQ;
            pc        <= word_align(RESET_PC);
            pend_pc   <= '0;
            buf_instr <= '0;
            buf_npc   <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            pend_pc   <= pend_n;
            buf_instr <= buf_instr_n;
            buf_npc   <= buf_npc_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pend_n      = pend_pc;
        buf_instr_n = buf_instr;
        buf_npc_n   = buf_npc;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ifid_instr  = imem_data_in;
        ifid_npc    = pc_seq;

        case (state)
            REQ: begin
                if (imem_ready_in) begin
                    if (redirect) begin
                        pc_n       = target;
                        ifid_flush = 1'b1;
                    end else if (stall_in) begin
                        buf_instr_n = imem_data_in;
                        buf_npc_n   = pc_seq;
                        pc_n        = pc_seq;
                        state_n     = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_n      = pc_seq;
                    end
                end else if (redirect) begin
                    // Request already in flight: keep the address, remember the target.
                    pend_n     = target;
                    ifid_flush = 1'b1;
                    state_n    = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pend_n     = target;
                    ifid_flush = 1'b1;
                end
                if (imem_ready_in) begin
                    pc_n    = redirect ? target : pend_pc;
                    state_n = REQ;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_n       = target;
                    ifid_flush = 1'b1;
                    state_n    = REQ;
                end else if (!stall_in) begin
                    ifid_load  = 1'b1;
                    ifid_instr = buf_instr;
                    ifid_npc   = buf_npc;
                    state_n    = REQ;
                end
            end
            default: state_n = REQ;
        endcase
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (ifid_load),
        .hold        (stall_in),
        .flush       (ifid_flush),
        .instr_next  (ifid_instr),
        .npc_next    (ifid_npc),
        .instruction (instruction_out),
        .npc         (npc_out),
        .valid       (valid_out)
    );

endmodule

// File: tb/tb_i_fetch.sv
// Self-checking bench for i_fetch: directed stimulus, a wait-state memory and a
// behavioural fetch model compared against the DUT every cycle.
module tb_i_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic        jump_in;
    logic [31:0] jump_target_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;
    logic [31:0] imem_data_in;
    logic [31:0] instruction_out;
    logic [31:0] npc_out;
    logic        valid_out;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_npc;
    logic        w_valid;

    int n_pass  = 0;
    int n_total = 0;
    int wait_cycles;
    int cnt;
    logic mem_en;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    i_fetch u_dut (
        .clk              (clk),
        .rst              (rst),
        .stall_in         (stall_in),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .jump_in          (jump_in),
        .jump_target_in   (jump_target_in),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .imem_ready_in    (imem_ready_in),
        .imem_data_in     (imem_data_in),
        .instruction_out  (instruction_out),
        .npc_out          (npc_out),
        .valid_out        (valid_out)
    );

    // Second instance exercises the PC wrap at the top of the address space.
    i_fetch #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_wrap (
        .clk              (clk),
        .rst              (rst),
        .stall_in         (1'b0),
        .branch_taken_in  (1'b0),
        .branch_target_in (32'h0),
        .jump_in          (1'b0),
        .jump_target_in   (32'h0),
        .imem_req_out     (w_req),
        .imem_addr_out    (w_addr),
        .imem_ready_in    (w_req),
        .imem_data_in     (w_addr),
        .instruction_out  (w_instr),
        .npc_out          (w_npc),
        .valid_out        (w_valid)
    );

    // Memory: returns the address as data after wait_cycles of a held request.
    assign imem_ready_in = mem_en && imem_req_out && (cnt >= wait_cycles);
    assign imem_data_in  = imem_addr_out;

    always @(posedge clk) begin
        if (rst || !imem_req_out || imem_ready_in) cnt <= 0;
        else                                       cnt <= cnt + 1;
    end

    // Behavioural model: a PC, an optional "in-flight fetch is stale" marker with
    // its replacement target, an optional held instruction, and the IF/ID contents.
    logic [31:0] m_pc, m_stale_tgt, m_hins, m_hnpc, m_ins, m_npc;
    logic        m_stale, m_held, m_val;
    logic        m_redir;
    logic [31:0] m_tgt;

    assign m_redir = jump_in | branch_taken_in;
    assign m_tgt   = (jump_in ? jump_target_in : branch_target_in) & ~32'd3;

    always @(posedge clk) begin
        if (rst) begin
            m_pc <= 32'h0; m_stale <= 1'b0; m_held <= 1'b0;
            m_ins <= 32'h0; m_npc <= 32'h0; m_val <= 1'b0;
        end else if (m_held) begin
            if (m_redir) begin
                m_held <= 1'b0; m_pc <= m_tgt;
                m_ins <= 32'h0; m_npc <= 32'h0; m_val <= 1'b0;
            end else if (!stall_in) begin
                m_held <= 1'b0; m_ins <= m_hins; m_npc <= m_hnpc; m_val <= 1'b1;
            end
        end else begin
            if (m_redir) begin
                m_ins <= 32'h0; m_npc <= 32'h0; m_val <= 1'b0;
            end
            if (imem_ready_in) begin
                m_stale <= 1'b0;
                if (m_redir)      m_pc <= m_tgt;
                else if (m_stale) m_pc <= m_stale_tgt;
                else begin
                    m_pc <= m_pc + 32'd4;
                    if (stall_in) begin
                        m_held <= 1'b1; m_hins <= imem_data_in; m_hnpc <= m_pc + 32'd4;
                    end else begin
                        m_ins <= imem_data_in; m_npc <= m_pc + 32'd4; m_val <= 1'b1;
                    end
                end
            end else if (m_redir) begin
                m_stale <= 1'b1; m_stale_tgt <= m_tgt;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_req",   {31'd0, imem_req_out}, {31'd0, !m_held});
            chk("m_addr",  imem_addr_out, m_pc);
            chk("m_instr", instruction_out, m_ins);
            chk("m_npc",   npc_out, m_npc);
            chk("m_valid", {31'd0, valid_out}, {31'd0, m_val});
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_ifid(input string name, input logic [31:0] ins, input logic [31:0] npc,
                            input logic val);
        chk({name, "_instr"}, instruction_out, ins);
        chk({name, "_npc"},   npc_out, npc);
        chk({name, "_valid"}, {31'd0, valid_out}, {31'd0, val});
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; branch_taken_in = 1'b0; jump_in = 1'b0;
        branch_target_in = 32'h0; jump_target_in = 32'h0;
        wait_cycles = 0; mem_en = 1'b1;
        @(negedge clk);
        cyc();
        check_en = 1'b1;
        chk_ifid("reset", 32'h0, 32'h0, 1'b0);
        chk("reset_req", {31'd0, imem_req_out}, 32'd1);
        chk("reset_addr", imem_addr_out, 32'h0);
        rst = 1'b0;

        // Zero-wait streaming.
        cyc(); chk_ifid("seq0", 32'h0, 32'h4, 1'b1);
        chk("wrap_instr", w_instr, 32'hFFFF_FFFC);
        chk("wrap_npc", w_npc, 32'h0);
        chk("wrap_addr", w_addr, 32'h0);
        cyc(); chk_ifid("seq1", 32'h4, 32'h8, 1'b1);
        chk("wrap_instr2", w_instr, 32'h0);
        cyc(); chk_ifid("seq2", 32'h8, 32'hC, 1'b1);

        // Two wait states at 0xC.
        wait_cycles = 2;
        cyc(); chk("ws_addr1", imem_addr_out, 32'hC); chk("ws_npc1", npc_out, 32'hC);
        cyc(); chk("ws_addr2", imem_addr_out, 32'hC); chk("ws_npc2", npc_out, 32'hC);
        cyc(); chk_ifid("ws_done", 32'hC, 32'h10, 1'b1);
        wait_cycles = 0;

        // Stall across a ready at 0x10.
        stall_in = 1'b1;
        cyc(); chk("st_req", {31'd0, imem_req_out}, 32'd0); chk_ifid("st_hold", 32'hC, 32'h10, 1'b1);
        cyc(); chk("st_req2", {31'd0, imem_req_out}, 32'd0);
        stall_in = 1'b0;
        cyc(); chk_ifid("st_rel", 32'h10, 32'h14, 1'b1); chk("st_addr", imem_addr_out, 32'h14);

        // Branch taken on a ready cycle, target low bits forced to zero.
        branch_taken_in = 1'b1; branch_target_in = 32'h43;
        cyc(); chk_ifid("br_flush", 32'h0, 32'h0, 1'b0); chk("br_addr", imem_addr_out, 32'h40);
        branch_taken_in = 1'b0;
        cyc(); chk_ifid("br_tgt", 32'h40, 32'h44, 1'b1);

        // Jump and branch together while the fetch at 0x44 is waiting.
        mem_en = 1'b0;
        jump_in = 1'b1; jump_target_in = 32'h100;
        branch_taken_in = 1'b1; branch_target_in = 32'h40;
        cyc(); chk("dr_addr1", imem_addr_out, 32'h44); chk("dr_valid1", {31'd0, valid_out}, 32'd0);
        jump_in = 1'b0; branch_taken_in = 1'b0;
        cyc(); chk("dr_addr2", imem_addr_out, 32'h44);
        mem_en = 1'b1;
        cyc(); chk("dr_addr3", imem_addr_out, 32'h100); chk("dr_valid3", {31'd0, valid_out}, 32'd0);
        cyc(); chk_ifid("dr_tgt", 32'h100, 32'h104, 1'b1);

        // Reset while draining.
        mem_en = 1'b0; branch_taken_in = 1'b1; branch_target_in = 32'h200;
        cyc(); chk("rd_addr", imem_addr_out, 32'h104);
        branch_taken_in = 1'b0; rst = 1'b1;
        cyc(); chk_ifid("rd_reset", 32'h0, 32'h0, 1'b0);
        chk("rd_addr0", imem_addr_out, 32'h0); chk("rd_req", {31'd0, imem_req_out}, 32'd1);
        rst = 1'b0; mem_en = 1'b1;

        // Mixed pattern of stalls, redirects and memory gaps, model-checked.
        for (int i = 0; i < 80; i++) begin
            stall_in         = (i % 5 == 2) || (i % 13 == 3);
            branch_taken_in  = (i % 7 == 3);
            branch_target_in = 32'h300 + 32'(i * 16);
            jump_in          = (i % 11 == 6);
            jump_target_in   = 32'h800 + 32'(i * 8) + 32'd2;
            mem_en           = (i % 3 != 1);
            cyc();
        end
        stall_in = 1'b0; branch_taken_in = 1'b0; jump_in = 1'b0; mem_en = 1'b1;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
